// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if: bundle of the control/status signals of one sr_ff_bank.
//   master : drives en, mode, s, r, err_clr; observes q, qb, err, conflict, conf_cnt
//   slave  : the bank itself
// WIDTH and CNT_W must match the parameters of the attached bank.
interface sr_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;       // 00=SR 01=JK 10=D 11=T
    logic [WIDTH-1:0] s;          // S / J / D / T per cell
    logic [WIDTH-1:0] r;          // R / K per cell
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             err;
    logic             conflict;
    logic [CNT_W-1:0] conf_cnt;

    modport master (
        output en, mode, s, r, err_clr,
        input  q, qb, err, conflict, conf_cnt
    );

    modport slave (
        input  en, mode, s, r, err_clr,
        output q, qb, err, conflict, conf_cnt
    );
endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH independent bistable cells sharing clock, enable and a runtime
// mode (SR / JK / D / T). SR-mode S=R=1 resolves by CONFLICT_POL; such events are
// flagged (conflict), made sticky (err) and counted (conf_cnt, saturating).
//   clk      : clock, posedge
//   rst      : synchronous reset, active-high, beats every other input
//   bus      : sr_ff_bank_if slave modport
//              in : en, mode, s, r, err_clr
//              out: q (registered), qb (~q, combinational), err, conflict, conf_cnt

// One cell of the bank. Holds unless en; next state is chosen by mode.
module sr_ff_cell #(
    parameter logic RST_BIT      = 1'b0,
    parameter int   CONFLICT_POL = 0      // 0=hold 1=set 2=reset on SR 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       s,
    input  logic       r,
    output logic       q
);
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    logic q_nxt;
    logic conflict_val;

    // Policy is a constant, so this collapses to a wire or a constant bit.
    always_comb begin
        conflict_val = q;
        if (CONFLICT_POL == 1)
            conflict_val = 1'b1;
        else if (CONFLICT_POL == 2)
            conflict_val = 1'b0;
    end

    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_SR: begin
                case ({s, r})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    2'b11:   q_nxt = conflict_val;
                    default: q_nxt = q;
                endcase
            end
            MODE_JK: begin
                case ({s, r})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            MODE_D:  q_nxt = s;
            MODE_T:  q_nxt = s ? ~q : q;
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_BIT;
        else if (en)
            q <= q_nxt;
    end
endmodule

module sr_ff_bank #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RST_VAL      = '0,
    parameter int               CONFLICT_POL = 0,
    parameter int               CNT_W        = 8
) (
    input  logic         clk,
    input  logic         rst,
    sr_ff_bank_if.slave  bus
);
    localparam logic [1:0]       MODE_SR = 2'b00;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_w;
    logic             err_q;
    logic             conflict_q;
    logic [CNT_W-1:0] cnt_q;
    logic             conf_ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell #(
            .RST_BIT      (RST_VAL[i]),
            .CONFLICT_POL (CONFLICT_POL)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (bus.en),
            .mode (bus.mode),
            .s    (bus.s[i]),
            .r    (bus.r[i]),
            .q    (q_w[i])
        );
    end

    // Any number of conflicting bits in one cycle is a single event.
    assign conf_ev = bus.en && (bus.mode == MODE_SR) && |(bus.s & bus.r);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            conflict_q <= conf_ev;
            if (conf_ev && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
            // A new event wins over a clear in the same cycle.
            if (conf_ev)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    assign bus.q        = q_w;
    assign bus.qb       = ~q_w;
    assign bus.err      = err_q;
    assign bus.conflict = conflict_q;
    assign bus.conf_cnt = cnt_q;
endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: three banks with different conflict policies, counter widths
// and reset values share one stimulus stream. A reference model pushes expected
// state per bank when each cycle is driven; it is popped and compared after the edge.
module tb_sr_ff_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] s = 8'h00;
    logic [7:0] r = 8'h00;
    logic       err_clr = 1'b0;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    sr_ff_bank_if #(.WIDTH(8), .CNT_W(8)) b0 ();
    sr_ff_bank_if #(.WIDTH(8), .CNT_W(2)) b1 ();
    sr_ff_bank_if #(.WIDTH(8), .CNT_W(3)) b2 ();

    assign b0.en = en;  assign b0.mode = mode;  assign b0.s = s;  assign b0.r = r;  assign b0.err_clr = err_clr;
    assign b1.en = en;  assign b1.mode = mode;  assign b1.s = s;  assign b1.r = r;  assign b1.err_clr = err_clr;
    assign b2.en = en;  assign b2.mode = mode;  assign b2.s = s;  assign b2.r = r;  assign b2.err_clr = err_clr;

    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CONFLICT_POL(1), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CONFLICT_POL(0), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'h3C), .CONFLICT_POL(2), .CNT_W(3)) u2 (.clk(clk), .rst(rst), .bus(b2));

    // Reference model state and per-bank constants.
    int         pol  [3] = '{1, 0, 2};
    int         cmax [3] = '{255, 3, 7};
    logic [7:0] rstv [3] = '{8'hA5, 8'h00, 8'h3C};
    logic [7:0] mq   [3];
    logic       merr [3];
    logic       mconf[3];
    int         mcnt [3];

    typedef struct {
        logic [7:0] q;
        logic       err;
        logic       conf;
        int         cnt;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model(input int k);
        logic       ev;
        logic [7:0] nq;
        if (rst) begin
            mq[k] = rstv[k]; merr[k] = 1'b0; mconf[k] = 1'b0; mcnt[k] = 0;
        end else if (!en) begin
            mconf[k] = 1'b0;
            if (err_clr) merr[k] = 1'b0;
        end else begin
            ev = (mode == 2'b00) && ((s & r) != 8'h00);
            nq = mq[k];
            for (int b = 0; b < 8; b++) begin
                case (mode)
                    2'b00: if (s[b] && !r[b]) nq[b] = 1'b1;
                           else if (!s[b] && r[b]) nq[b] = 1'b0;
                           else if (s[b] && r[b]) nq[b] = (pol[k] == 1) ? 1'b1 :
                                                          (pol[k] == 2) ? 1'b0 : mq[k][b];
                    2'b01: if (s[b] && r[b]) nq[b] = ~mq[k][b];
                           else if (s[b]) nq[b] = 1'b1;
                           else if (r[b]) nq[b] = 1'b0;
                    2'b10: nq[b] = s[b];
                    default: if (s[b]) nq[b] = ~mq[k][b];
                endcase
            end
            mq[k] = nq;
            mconf[k] = ev;
            if (ev && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
            if (ev) merr[k] = 1'b1;
            else if (err_clr) merr[k] = 1'b0;
        end
    endtask

    task automatic tick(input logic r_, input logic e_, input logic [1:0] m_,
                        input logic [7:0] s_, input logic [7:0] rr_, input logic ec_);
        exp_t       e;
        logic [7:0] aq, aqb;
        logic       aerr, aconf;
        int         acnt;
        rst = r_; en = e_; mode = m_; s = s_; r = rr_; err_clr = ec_;
        for (int k = 0; k < 3; k++) begin
            model(k);
            e.q = mq[k]; e.err = merr[k]; e.conf = mconf[k]; e.cnt = mcnt[k];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                case (k)
                    0: begin aq = b0.q; aqb = b0.qb; aerr = b0.err; aconf = b0.conflict; acnt = int'(b0.conf_cnt); end
                    1: begin aq = b1.q; aqb = b1.qb; aerr = b1.err; aconf = b1.conflict; acnt = int'(b1.conf_cnt); end
                    default: begin aq = b2.q; aqb = b2.qb; aerr = b2.err; aconf = b2.conflict; acnt = int'(b2.conf_cnt); end
                endcase
                chk($sformatf("u%0d.q", k),        {24'd0, aq},     {24'd0, e.q});
                chk($sformatf("u%0d.qb", k),       {24'd0, aqb},    {24'd0, ~e.q});
                chk($sformatf("u%0d.err", k),      {31'd0, aerr},   {31'd0, e.err});
                chk($sformatf("u%0d.conflict", k), {31'd0, aconf},  {31'd0, e.conf});
                chk($sformatf("u%0d.conf_cnt", k), acnt,            e.cnt);
            end
        end
    endtask

    localparam logic [1:0] SR = 2'b00, JK = 2'b01, D = 2'b10, T = 2'b11;

    initial begin
        // reset for two cycles
        tick(1, 0, SR, 8'h00, 8'h00, 0);
        tick(1, 1, SR, 8'hFF, 8'hFF, 1);
        // SR basic set / hold / reset
        tick(0, 1, SR, 8'h0F, 8'hF0, 0);
        tick(0, 1, SR, 8'h00, 8'h00, 0);
        tick(0, 1, SR, 8'h00, 8'h0C, 0);
        // clear to 00, then three conflict cycles
        tick(0, 1, D,  8'h00, 8'h00, 0);
        repeat (3) tick(0, 1, SR, 8'hFF, 8'hFF, 0);
        // err_clr without, then with, a conflict
        tick(0, 1, SR, 8'h00, 8'h00, 1);
        tick(0, 1, SR, 8'h01, 8'h01, 1);
        // JK toggle, T toggle, D load
        tick(0, 1, D,  8'h55, 8'h00, 0);
        tick(0, 1, JK, 8'hFF, 8'hFF, 0);
        tick(0, 1, T,  8'h0F, 8'h00, 0);
        tick(0, 1, D,  8'h3C, 8'hFF, 0);
        // saturation, then enable low holds everything
        repeat (5) tick(0, 1, SR, 8'hFF, 8'hFF, 0);
        tick(0, 0, SR, 8'hFF, 8'hFF, 0);
        tick(0, 0, T,  8'hFF, 8'h00, 0);
        tick(0, 0, SR, 8'h00, 8'h00, 1);
        // random traffic with occasional resets
        for (int n = 0; n < 80; n++)
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0));
        // reset arriving together with a conflict and err_clr
        repeat (2) tick(0, 1, SR, 8'hF0, 8'h30, 0);
        tick(1, 1, SR, 8'hFF, 8'hFF, 1);
        tick(0, 1, SR, 8'h81, 8'h00, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
